// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: owner encoding, fixed-priority owner and word width shared by the SRAM port arbiter
package sram_port_arbiter_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;
  localparam owner_e PRIO_OWNER = OWN_DATA;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating starvation counter; ports clk, rst, inc (count a lost arbitration), clr (waiter served or gone) -> at_limit
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_limit = cnt_q == W'(LIMIT);
  always_comb cnt_d = clr ? '0 : (inc && !at_limit) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sync-read SRAM between fetch (inst_*) and load/store (data_*) ports, drives mem_*, pulses *_valid one cycle after grant, counts grants
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [WORD_W-1:0] inst_rdata,
  output logic              inst_valid,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_wdata,
  output logic [WORD_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  inst_grant_cnt,
  output logic [CNT_W-1:0]  data_grant_cnt
);
  owner_e owner_q, owner_d;
  logic store_q, store_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d, data_cnt_q, data_cnt_d;
  logic inst_elig, data_elig, gnt_inst, gnt_data, at_limit;
  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (gnt_data && inst_req),
    .clr      (gnt_inst || !inst_req),
    .at_limit (at_limit)
  );
  always_comb begin
    inst_elig  = inst_req && owner_q != OWN_INST;
    data_elig  = data_req && owner_q != OWN_DATA;
    gnt_data   = data_elig && (!inst_elig || (!at_limit && PRIO_OWNER == OWN_DATA));
    gnt_inst   = inst_elig && !gnt_data;
    owner_d    = gnt_data ? OWN_DATA : gnt_inst ? OWN_INST : OWN_NONE;
    store_d    = gnt_data && data_wen != 4'b0;
    inst_cnt_d = inst_cnt_q + CNT_W'(gnt_inst);
    data_cnt_d = data_cnt_q + CNT_W'(gnt_data);
    mem_en     = !rst && (gnt_inst || gnt_data);
    mem_wen    = (!rst && gnt_data) ? data_wen : 4'b0;
    mem_addr   = rst ? '0 : gnt_data ? data_addr : gnt_inst ? inst_addr : '0;
    mem_wdata  = gnt_data ? data_wdata : '0;
    inst_valid = owner_q == OWN_INST;
    data_valid = owner_q == OWN_DATA;
    inst_rdata = inst_valid ? mem_rdata : '0;
    data_rdata = (data_valid && !store_q) ? mem_rdata : '0;
  end
  assign inst_grant_cnt = inst_cnt_q;
  assign data_grant_cnt = data_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      store_q    <= 1'b0;
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      store_q    <= store_d;
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end
endmodule
